// File: rtl/viterbi_acs.sv
// Hard-decision add-compare-select stage for the K=7, rate-1/2 (171/133 octal) code.
// Each accepted symbol updates 64 modular path metrics and registers survivor bits plus the best state.
module viterbi_acs #(
  parameter int PM_W    = 8,
  parameter int PM_INIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        dv_in,
  input  logic [1:0]  din,
  output logic        dv_out,
  output logic [63:0] dec,
  output logic [5:0]  best_state
);

  localparam int NS = 64;

  logic [PM_W-1:0] pm     [NS];
  logic [PM_W-1:0] pm_nxt [NS];
  logic [NS-1:0]   sel;
  logic [5:0]      best_nxt;

  // Expected {G1,G0} for the transition into ns. j is the bit that leaves the register (lag 6).
  function automatic logic [1:0] branch_out(input logic [5:0] ns, input logic j);
    logic g0;
    logic g1;
    g0 = ns[5] ^ ns[4] ^ ns[3] ^ ns[2] ^ j;
    g1 = ns[5] ^ ns[3] ^ ns[2] ^ ns[0] ^ j;
    return {g1, g0};
  endfunction

  function automatic logic [PM_W-1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return PM_W'(x[0]) + PM_W'(x[1]);
  endfunction

  always_comb begin
    logic [5:0]      ns;
    logic [PM_W-1:0] m0;
    logic [PM_W-1:0] m1;
    logic [PM_W-1:0] diff;
    // NOTE: every variable gets a default before any conditional use so no latch is inferred.
    ns   = '0;
    m0   = '0;
    m1   = '0;
    diff = '0;
    sel  = '0;
    for (int i = 0; i < NS; i++) begin
      pm_nxt[i] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      ns   = 6'(i);
      m0   = pm[{ns[4:0], 1'b0}] + hamming(din, branch_out(ns, 1'b0));
      m1   = pm[{ns[4:0], 1'b1}] + hamming(din, branch_out(ns, 1'b1));
      // Modular compare: a set MSB of the difference means m1 is strictly smaller.
      diff      = m1 - m0;
      sel[i]    = diff[PM_W-1];
      pm_nxt[i] = diff[PM_W-1] ? m1 : m0;
    end
  end

  // Linear scan with strict-less update keeps the lowest index on ties.
  always_comb begin
    logic [PM_W-1:0] best_m;
    logic [PM_W-1:0] d;
    best_nxt = '0;
    best_m   = pm_nxt[0];
    d        = '0;
    for (int i = 1; i < NS; i++) begin
      d = pm_nxt[i] - best_m;
      if (d[PM_W-1]) begin
        best_nxt = 6'(i);
        best_m   = pm_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the metric array is reset, not left uninitialised, because decoding depends on its start values.
      for (int i = 0; i < NS; i++) begin
        pm[i] <= (i == 0) ? '0 : PM_W'(PM_INIT);
      end
      dv_out     <= 1'b0;
      dec        <= '0;
      best_state <= '0;
    end else begin
      // NOTE: non-blocking assignments so every metric updates from the previous beat's values.
      dv_out <= dv_in & ~clr;
      if (clr) begin
        for (int i = 0; i < NS; i++) begin
          pm[i] <= (i == 0) ? '0 : PM_W'(PM_INIT);
        end
      end else if (dv_in) begin
        for (int i = 0; i < NS; i++) begin
          pm[i] <= pm_nxt[i];
        end
        dec        <= sel;
        best_state <= best_nxt;
      end
    end
  end

endmodule
